// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU with a valid/ready request side and
// a valid/ready result side. Single-cycle ops complete one cycle after
// acceptance. MUL (shift-add) and DIV (restoring) iterate WIDTH cycles.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer holds valid (and its data) until that edge. The
// consumer may change ready freely. Request side: in_valid/in_ready, with
// in_ready high only in IDLE. Result side: out_valid/out_ready, with result,
// result_hi, status_out and err held stable while out_valid is 1 and
// out_ready is 0.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             use_carry,
    input  logic             no_wr,
    input  logic [6:0]       status_in,
    input  logic [WIDTH-1:0] opnd0,
    input  logic [WIDTH-1:0] opnd1,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [6:0]       status_out,
    output logic             err,
    output logic [1:0]       dbg_state
);

    // Flag bit positions in the shared status word.
    localparam int STAT_CF = 0;
    localparam int STAT_PF = 1;
    localparam int STAT_AF = 2;
    localparam int STAT_ZF = 3;
    localparam int STAT_SF = 4;
    localparam int STAT_DF = 5;
    localparam int STAT_OF = 6;

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               nowr_q;
    logic [6:0]         stat_q;
    logic [WIDTH-1:0]   acc_hi;   // MUL partial high word / DIV remainder
    logic [WIDTH-1:0]   acc_lo;   // MUL multiplier bits / DIV dividend->quotient
    logic [WIDTH-1:0]   oper_q;   // MUL multiplicand / DIV divisor

    // Single-cycle datapath signals.
    logic               cin;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     dif_ext;
    logic [CNT_W-2:0]   sh_cnt;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic               upd_pzs;
    logic [WIDTH-1:0]   s_res;
    logic [6:0]         s_stat;
    logic               s_err;
    logic               s_multi;

    // Iteration-step signals.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nxt;
    logic [WIDTH-1:0]   mul_lo_nxt;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_dif;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_nxt;
    logic [WIDTH-1:0]   div_quo_nxt;
    logic [6:0]         mul_stat;

    assign in_ready  = (state == S_IDLE);
    assign dbg_state = state;

    // Single-cycle ops evaluated from the live inputs, consumed only at acceptance.
    always_comb begin
        s_res   = '0;
        s_stat  = status_in;
        s_err   = 1'b0;
        s_multi = 1'b0;
        upd_pzs = 1'b0;
        cin     = use_carry & status_in[STAT_CF];
        sum_ext = {1'b0, opnd0} + {1'b0, opnd1} + {{WIDTH{1'b0}}, cin};
        dif_ext = {1'b0, opnd0} - {1'b0, opnd1} - {{WIDTH{1'b0}}, cin};
        sh_cnt  = opnd1[CNT_W-2:0];
        // The extra bit catches the last bit shifted out in either direction.
        shl_ext = {1'b0, opnd0} << sh_cnt;
        shr_ext = {opnd0, 1'b0} >> sh_cnt;
        case (op)
            OP_ADD: begin
                s_res           = sum_ext[WIDTH-1:0];
                s_stat[STAT_CF] = sum_ext[WIDTH];
                s_stat[STAT_OF] = (opnd0[MSB] == opnd1[MSB]) && (s_res[MSB] != opnd0[MSB]);
                s_stat[STAT_AF] = opnd0[4] ^ opnd1[4] ^ s_res[4];
                upd_pzs         = 1'b1;
            end
            OP_SUB: begin
                s_res           = dif_ext[WIDTH-1:0];
                s_stat[STAT_CF] = dif_ext[WIDTH];
                s_stat[STAT_OF] = (opnd0[MSB] != opnd1[MSB]) && (s_res[MSB] != opnd0[MSB]);
                s_stat[STAT_AF] = opnd0[4] ^ opnd1[4] ^ s_res[4];
                upd_pzs         = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (op == OP_AND)      s_res = opnd0 & opnd1;
                else if (op == OP_OR)  s_res = opnd0 | opnd1;
                else                   s_res = opnd0 ^ opnd1;
                s_stat[STAT_CF] = 1'b0;
                s_stat[STAT_OF] = 1'b0;
                s_stat[STAT_AF] = 1'b0;
                upd_pzs         = 1'b1;
            end
            OP_SHL: begin
                if (sh_cnt == '0) begin
                    s_res = opnd0;
                end else begin
                    s_res           = shl_ext[WIDTH-1:0];
                    s_stat[STAT_CF] = shl_ext[WIDTH];
                    if (sh_cnt == {{(CNT_W-2){1'b0}}, 1'b1})
                        s_stat[STAT_OF] = s_res[MSB] ^ shl_ext[WIDTH];
                    upd_pzs = 1'b1;
                end
            end
            OP_SHR: begin
                if (sh_cnt == '0) begin
                    s_res = opnd0;
                end else begin
                    s_res           = shr_ext[WIDTH:1];
                    s_stat[STAT_CF] = shr_ext[0];
                    if (sh_cnt == {{(CNT_W-2){1'b0}}, 1'b1})
                        s_stat[STAT_OF] = opnd0[MSB];
                    upd_pzs = 1'b1;
                end
            end
            OP_MUL: s_multi = 1'b1;
            OP_DIV: begin
                if (opnd1 == '0) s_err   = 1'b1;
                else             s_multi = 1'b1;
            end
            default: s_err = 1'b1;
        endcase
        if (upd_pzs) begin
            s_stat[STAT_PF] = ~^s_res[7:0];
            s_stat[STAT_ZF] = (s_res == '0);
            s_stat[STAT_SF] = s_res[MSB];
        end
        s_stat[STAT_DF] = status_in[STAT_DF];
        if (no_wr) begin
            s_res  = '0;
            s_stat = status_in;
        end
    end

    // One shift-add (MUL) or restore-subtract (DIV) step from the held state.
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, oper_q} : {(WIDTH+1){1'b0}});
        mul_hi_nxt  = mul_sum[WIDTH:1];
        mul_lo_nxt  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_sh      = {acc_hi, acc_lo[WIDTH-1]};
        div_dif     = div_sh - {1'b0, oper_q};
        // The partial remainder is always below 2*divisor, so the top bit of
        // the difference is a clean borrow.
        div_ge      = ~div_dif[WIDTH];
        div_rem_nxt = div_ge ? div_dif[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_quo_nxt = {acc_lo[WIDTH-2:0], div_ge};
        mul_stat          = stat_q;
        mul_stat[STAT_CF] = (mul_hi_nxt != '0);
        mul_stat[STAT_OF] = (mul_hi_nxt != '0);
    end

    // Control FSM and registered outputs; reset beats abort beats handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            is_div     <= 1'b0;
            nowr_q     <= 1'b0;
            stat_q     <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            oper_q     <= '0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
            result_hi  <= '0;
            status_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (s_multi) begin
                            state  <= S_BUSY;
                            cnt    <= CNT_W'(WIDTH);
                            is_div <= (op == OP_DIV);
                            nowr_q <= no_wr;
                            stat_q <= status_in;
                            acc_hi <= '0;
                            acc_lo <= (op == OP_DIV) ? opnd0 : opnd1;
                            oper_q <= (op == OP_DIV) ? opnd1 : opnd0;
                        end else begin
                            state      <= S_DONE;
                            out_valid  <= 1'b1;
                            err        <= s_err;
                            result     <= s_res;
                            result_hi  <= '0;
                            status_out <= s_stat;
                        end
                    end
                end
                S_BUSY: begin
                    if (abort) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end else begin
                        acc_hi <= is_div ? div_rem_nxt : mul_hi_nxt;
                        acc_lo <= is_div ? div_quo_nxt : mul_lo_nxt;
                        cnt    <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            err       <= 1'b0;
                            if (nowr_q) begin
                                result     <= '0;
                                result_hi  <= '0;
                                status_out <= stat_q;
                            end else if (is_div) begin
                                result     <= div_quo_nxt;
                                result_hi  <= div_rem_nxt;
                                status_out <= stat_q;
                            end else begin
                                result     <= mul_lo_nxt;
                                result_hi  <= mul_hi_nxt;
                                status_out <= mul_stat;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (abort || out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (WIDTH=32).
// Flag layout: CF=0 PF=1 AF=2 ZF=3 SF=4 DF=5 OF=6.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic         use_carry;
    logic         no_wr;
    logic [6:0]   status_in;
    logic [W-1:0] opnd0;
    logic [W-1:0] opnd1;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [6:0]   status_out;
    logic         err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    // Clock and DUT.
    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .use_carry(use_carry), .no_wr(no_wr), .status_in(status_in),
        .opnd0(opnd0), .opnd1(opnd1), .abort(abort), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .result_hi(result_hi),
        .status_out(status_out), .err(err), .dbg_state(dbg_state)
    );

    // Driver tasks: inputs change and outputs are sampled 1ns after posedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 1'b0; op = 4'd0; use_carry = 1'b0; no_wr = 1'b0;
        status_in = 7'h00; opnd0 = '0; opnd1 = '0; abort = 1'b0;
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [6:0] st, input logic uc, input logic nw);
        op = o; opnd0 = a; opnd1 = b; status_in = st; use_carry = uc; no_wr = nw;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic wait_out(input int max, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; set_idle(); out_ready = 1'b0;
        tick(); tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if ({result, result_hi, status_out, err} !== '0) begin errors++; $display("FAIL rst_outputs got %h %h %h %b exp 0", result, result_hi, status_out, err); end
        rst_n = 1'b1;
        tick();
        // Reset in the middle of a MUL.
        issue(4'd7, 32'h0001_0000, 32'h0001_0000, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL mid_mul_busy got %0d exp 1", dbg_state); end
        rst_n = 1'b0;
        tick();
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL mid_rst_state got %0d exp 0", dbg_state); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_hs got in_ready %b out_valid %b exp 1 0", in_ready, out_valid); end
        checks++; if ({result, result_hi, status_out, err} !== '0) begin errors++; $display("FAIL mid_rst_outputs got %h %h %h %b exp 0", result, result_hi, status_out, err); end
        rst_n = 1'b1;
        wait_out(40, n);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ghost got out_valid %b exp 0", out_valid); end
    endtask

    task automatic test_add_sub();
        issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 7'h00, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_in_ready got %b exp 0", in_ready); end
        checks++; if (result !== 32'h0 || result_hi !== 32'h0) begin errors++; $display("FAIL add_res got %h %h exp 0 0", result_hi, result); end
        checks++; if (status_out !== 7'h0F) begin errors++; $display("FAIL add_flags got %h exp 0f", status_out); end
        drain();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_drain got out_valid %b in_ready %b exp 0 1", out_valid, in_ready); end
        // SUB with DF set: DF must survive.
        issue(4'd1, 32'h8000_0000, 32'h0000_0001, 7'h20, 1'b0, 1'b0);
        checks++; if (result !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_res got %h exp 7fffffff", result); end
        checks++; if (status_out !== 7'h66) begin errors++; $display("FAIL sub_flags got %h exp 66", status_out); end
        drain();
        // ADD with carry-in: 5+3+1 = 9.
        issue(4'd0, 32'd5, 32'd3, 7'h01, 1'b1, 1'b0);
        checks++; if (result !== 32'd9 || status_out !== 7'h02) begin errors++; $display("FAIL adc got %h flags %h exp 9 02", result, status_out); end
        drain();
        // SUB with borrow: 1-1-1 = -1, CF=1.
        issue(4'd1, 32'd1, 32'd1, 7'h01, 1'b1, 1'b0);
        checks++; if (result !== 32'hFFFF_FFFF || status_out !== 7'h17) begin errors++; $display("FAIL sbb got %h flags %h exp ffffffff 17", result, status_out); end
        drain();
    endtask

    task automatic test_logic();
        issue(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 7'h7F, 1'b0, 1'b0);
        checks++; if (result !== 32'h00F0_00F0 || status_out !== 7'h22) begin errors++; $display("FAIL and got %h flags %h exp 00f000f0 22", result, status_out); end
        drain();
        issue(4'd3, 32'h8000_0000, 32'h0, 7'h00, 1'b0, 1'b0);
        checks++; if (result !== 32'h8000_0000 || status_out !== 7'h12) begin errors++; $display("FAIL or got %h flags %h exp 80000000 12", result, status_out); end
        drain();
        issue(4'd4, 32'h1234_5678, 32'h1234_5678, 7'h00, 1'b0, 1'b0);
        checks++; if (result !== 32'h0 || status_out !== 7'h0A) begin errors++; $display("FAIL xor got %h flags %h exp 0 0a", result, status_out); end
        drain();
    endtask

    task automatic test_shift();
        issue(4'd5, 32'h8000_0001, 32'd1, 7'h00, 1'b0, 1'b0);
        checks++; if (result !== 32'd2 || status_out !== 7'h41) begin errors++; $display("FAIL shl1 got %h flags %h exp 2 41", result, status_out); end
        drain();
        issue(4'd6, 32'h1234_5678, 32'd32, 7'h7F, 1'b0, 1'b0);
        checks++; if (result !== 32'h1234_5678 || status_out !== 7'h7F) begin errors++; $display("FAIL shr32 got %h flags %h exp 12345678 7f", result, status_out); end
        drain();
        issue(4'd6, 32'h8000_0008, 32'd4, 7'h44, 1'b0, 1'b0);
        checks++; if (result !== 32'h0800_0000 || status_out !== 7'h47) begin errors++; $display("FAIL shr4 got %h flags %h exp 08000000 47", result, status_out); end
        drain();
        issue(4'd6, 32'h8000_0002, 32'd1, 7'h00, 1'b0, 1'b0);
        checks++; if (result !== 32'h4000_0001 || status_out !== 7'h40) begin errors++; $display("FAIL shr1 got %h flags %h exp 40000001 40", result, status_out); end
        drain();
    endtask

    task automatic test_mul();
        int n;
        logic [W-1:0] h_res, h_hi;
        logic [6:0]   h_st;
        issue(4'd7, 32'h0001_0000, 32'h0001_0000, 7'h1C, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy got out_valid %b in_ready %b exp 0 0", out_valid, in_ready); end
        opnd0 = 32'hDEAD_BEEF; opnd1 = 32'hCAFE_F00D; status_in = 7'h7F;
        wait_out(40, n);
        checks++; if (out_valid !== 1'b1 || n !== 32) begin errors++; $display("FAIL mul_latency got valid %b after %0d exp 1 after 32", out_valid, n); end
        checks++; if (result !== 32'h0 || result_hi !== 32'h1) begin errors++; $display("FAIL mul_res got %h_%h exp 00000001_00000000", result_hi, result); end
        checks++; if (status_out !== 7'h5D || err !== 1'b0) begin errors++; $display("FAIL mul_flags got %h err %b exp 5d 0", status_out, err); end
        h_res = result; h_hi = result_hi; h_st = status_out;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== h_res || result_hi !== h_hi || status_out !== h_st) begin
                errors++; $display("FAIL mul_hold%0d got v %b r %b %h %h %h exp 1 0 %h %h %h", i, out_valid, in_ready, result_hi, result, status_out, h_hi, h_res, h_st);
            end
        end
        drain();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mul_drain got out_valid %b in_ready %b exp 0 1", out_valid, in_ready); end
        issue(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'h00, 1'b0, 1'b0);
        wait_out(40, n);
        checks++; if (result !== 32'h0000_0001 || result_hi !== 32'hFFFF_FFFE || status_out !== 7'h41) begin errors++; $display("FAIL mul_max got %h_%h flags %h exp fffffffe_00000001 41", result_hi, result, status_out); end
        drain();
    endtask

    task automatic test_div();
        int n;
        issue(4'd8, 32'd100, 32'd7, 7'h55, 1'b0, 1'b0);
        wait_out(40, n);
        checks++; if (n !== 32 || result !== 32'd14 || result_hi !== 32'd2) begin errors++; $display("FAIL div_100_7 got q %0d r %0d after %0d exp 14 2 after 32", result, result_hi, n); end
        checks++; if (status_out !== 7'h55 || err !== 1'b0) begin errors++; $display("FAIL div_flags got %h err %b exp 55 0", status_out, err); end
        drain();
        issue(4'd8, 32'hFFFF_FFFF, 32'h10, 7'h00, 1'b0, 1'b0);
        wait_out(40, n);
        checks++; if (result !== 32'h0FFF_FFFF || result_hi !== 32'hF) begin errors++; $display("FAIL div_max got q %h r %h exp 0fffffff f", result, result_hi); end
        drain();
        issue(4'd8, 32'd5, 32'd0, 7'h2A, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL div0_err got valid %b err %b exp 1 1", out_valid, err); end
        checks++; if (result !== 32'h0 || result_hi !== 32'h0 || status_out !== 7'h2A) begin errors++; $display("FAIL div0_res got %h %h flags %h exp 0 0 2a", result, result_hi, status_out); end
        drain();
    endtask

    task automatic test_nowr_illegal();
        issue(4'd0, 32'd1, 32'd1, 7'h33, 1'b0, 1'b1);
        checks++; if (result !== 32'h0 || status_out !== 7'h33 || err !== 1'b0) begin errors++; $display("FAIL nowr_add got %h flags %h err %b exp 0 33 0", result, status_out, err); end
        drain();
        issue(4'd12, 32'd9, 32'd9, 7'h11, 1'b0, 1'b0);
        checks++; if (err !== 1'b1 || result !== 32'h0 || status_out !== 7'h11) begin errors++; $display("FAIL illegal12 got err %b res %h flags %h exp 1 0 11", err, result, status_out); end
        drain();
        issue(4'd15, 32'd9, 32'd9, 7'h05, 1'b0, 1'b1);
        checks++; if (err !== 1'b1 || result !== 32'h0 || status_out !== 7'h05) begin errors++; $display("FAIL illegal15_nowr got err %b res %h flags %h exp 1 0 05", err, result, status_out); end
        drain();
    endtask

    task automatic test_abort();
        issue(4'd8, 32'd100, 32'd7, 7'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_busy got out_valid %b in_ready %b exp 0 1", out_valid, in_ready); end
        issue(4'd0, 32'd2, 32'd3, 7'h00, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || result !== 32'd5 || result_hi !== 32'h0 || status_out !== 7'h02) begin errors++; $display("FAIL abort_add got v %b %h %h flags %h exp 1 0 5 02", out_valid, result_hi, result, status_out); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_done got out_valid %b in_ready %b exp 0 1", out_valid, in_ready); end
        // abort in IDLE is ignored: a request in the same cycle still goes through.
        abort = 1'b1;
        issue(4'd4, 32'h0000_00FF, 32'h0000_000F, 7'h00, 1'b0, 1'b0);
        abort = 1'b0;
        checks++; if (out_valid !== 1'b1 || result !== 32'h0000_00F0) begin errors++; $display("FAIL abort_idle got v %b res %h exp 1 000000f0", out_valid, result); end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        issue(4'd0, 32'd10, 32'd20, 7'h00, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin errors++; $display("FAIL b2b_first got v %b res %0d exp 1 30", out_valid, result); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap got v %b in_ready %b exp 0 1", out_valid, in_ready); end
        issue(4'd1, 32'd10, 32'd20, 7'h00, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFF6) begin errors++; $display("FAIL b2b_second got v %b res %h exp 1 fffffff6", out_valid, result); end
        tick();
        out_ready = 1'b0;
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_mul();
        test_div();
        test_nowr_illegal();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a task never returns.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the combinational execute-stage ALU.
- Adds a valid/ready handshake, registered outputs, iterative shift-add multiply and restoring divide producing a high/remainder word, shifts with x86 flag rules, and divide-by-zero / illegal-op reporting.
- Sits between operand fetch and writeback in execute. Status bit positions are the `STAT_* indices from defines.v.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, ≥8.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request (IDLE only).
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL, 8 DIV, 9–15 illegal.
- use_carry  in  1  ADD/SUB: add status_in[CF] into the result.
- no_wr  in  1  flags pass through unchanged; result forced to 0.
- status_in  in  7  incoming flags.
- opnd0  in  WIDTH  first operand (dividend).
- opnd1  in  WIDTH  second operand, shift count, or divisor.
- abort  in  1  synchronous flush.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  low result or quotient.
- result_hi  out  WIDTH  MUL high word or DIV remainder; 0 for other ops.
- status_out  out  7  updated flags.
- err  out  1  divide-by-zero or illegal op.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - out_valid, err, result, result_hi, status_out all clear to 0; in_ready=1 the cycle after reset.
  - Reset overrides everything, including mid-BUSY.
- IDLE (in_ready=1):
  - Request is accepted when in_valid & in_ready. All inputs are captured at acceptance; later input changes are ignored.
  - ADD, SUB, logic ops, shifts, illegal ops and DIV-by-zero go to DONE. out_valid=1 at acceptance+1.
  - MUL and DIV with nonzero divisor go to BUSY, with counter=WIDTH.
- BUSY:
  - One shift-add or restore-subtract step per cycle; counter decrements.
  - On the step where counter=1, go to DONE. out_valid=1 at acceptance+WIDTH+1.
- DONE:
  - out_valid=1; outputs are held stable until out_ready=1.
  - Handshake then returns to IDLE; in_ready is re-asserted the next cycle.
  - Minimum throughput is one op per 2 cycles.
- abort:
  - Asserted in BUSY or DONE: next state is IDLE and out_valid=0; outputs are not otherwise defined.
  - Ignored in IDLE.
  - reset > abort > handshake.
- Arithmetic:
  - Operations are computed at WIDTH+1 bits.
  - ADD: CF = carry out.
  - SUB: CF = borrow (opnd0 < opnd1 + cin).
  - OF, ADD: operands have the same sign and the result sign differs.
  - OF, SUB: operand signs differ and the result sign differs from opnd0.
  - AF = opnd0[4]^opnd1[4]^res[4].
  - PF = even parity of res[7:0].
  - ZF = (res==0); SF = res[WIDTH-1].
  - AND/OR/XOR: CF=OF=0, AF=0.
- Shifts:
  - Count = opnd1[CNT_W-2:0] (mod WIDTH).
  - Count 0: result=opnd0, flags unchanged.
  - Otherwise CF = last bit shifted out.
  - OF for count 1: SHL = res[MSB]^CF, SHR = opnd0[MSB].
  - OF for count >1: preserved.
  - AF preserved; PF/ZF/SF from the result.
- MUL (unsigned):
  - {result_hi,result} = full 2·WIDTH product.
  - CF=OF=(result_hi≠0); other flags preserved.
- DIV (unsigned):
  - result = quotient, result_hi = remainder; all flags preserved.
  - Divisor 0: err=1, result=result_hi=0, flags=status_in.
- Illegal op: err=1, result=0, flags=status_in.
- no_wr: status_out=status_in, result=result_hi=0. err still reports faults.
- DF is never modified.

Test Plan:
- Reset mid-MUL (rst_n low at BUSY cycle 10) → next cycle IDLE, out_valid=0, all outputs 0, in_ready=1.
- ADD 0xFFFFFFFF+0x00000001, use_carry=0 → out_valid at +1; result=0, CF=1, ZF=1, PF=1, AF=1, OF=0. Then SUB 0x80000000−1 → result=0x7FFFFFFF, OF=1, CF=0.
- MUL 0x00010000×0x00010000 → out_valid exactly at acceptance+33; result=0, result_hi=1, CF=OF=1. Hold out_ready=0 for 5 cycles → outputs stable, in_ready=0.
- DIV 100/7 → result=14, result_hi=2, flags=status_in. DIV 5/0 → err=1 at +1, result=0.
- SHL 0x80000001 by 1 → result=2, CF=1, OF=1. SHR by 32 (masked to 0) → result=opnd0, flags unchanged.
- abort during DIV BUSY cycle 5, then immediate ADD 2+3 → no stale out_valid; result=5 at +1. Op 12 → err=1.
